// File: rtl/echo_recorder_pkg.sv
// Shared types, FSM state codes and saturation helper for the echo recorder.
package echo_recorder_pkg;

  localparam int unsigned STATE_W = 3;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RECORD = 3'd1;
  localparam logic [2:0] ST_PLAY   = 3'd2;
  localparam logic [2:0] ST_MIX    = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam int unsigned TAP_W = 3;
  typedef logic [TAP_W-1:0] tap_idx_t;

  localparam int unsigned SAT_IN_W = 32;

  // Clamp a wide signed value to the range of a signed word of the given width.
  function automatic logic signed [SAT_IN_W-1:0] sat_to_sample(
    input logic signed [SAT_IN_W-1:0] value,
    input int unsigned                width
  );
    logic signed [SAT_IN_W-1:0] hi;
    logic signed [SAT_IN_W-1:0] lo;
    hi = (SAT_IN_W'(1) << (width - 1)) - SAT_IN_W'(1);
    lo = -hi - SAT_IN_W'(1);
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/echo_recorder_sample.sv
// Simple dual-port sample RAM: one write port, one read port with 2-cycle registered read.
module sample_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_q1;

  // Array is intentionally not reset; a take is only valid up to its recorded length.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_q1   <= mem[rd_addr];
    rd_data <= rd_q1;
  end

endmodule

// File: rtl/echo_recorder.sv
// Audio take recorder with multi-tap echo playback.
// Define ECHO_LOOP_PLAYBACK_EN to loop the take instead of stopping after one pass.
module echo_recorder
  import echo_recorder_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned DEPTH    = 18000,
  parameter int unsigned NUM_TAPS = 2,
  parameter int unsigned TAP_STEP = 1500
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         record_in,
  input  logic                         play_in,
  input  logic signed [SAMPLE_W-1:0]   audio_in,
  input  logic                         audio_valid_in,
  output logic signed [SAMPLE_W-1:0]   sample_out,
  output logic                         sample_valid_out,
  output logic [$clog2(DEPTH+1)-1:0]   recording_length,
  output logic                         full_out,
  output logic                         finish_out,
  output logic                         overrun_out
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned LEN_W  = $clog2(DEPTH + 1);
  localparam int unsigned ACC_W  = SAMPLE_W + 2;
  localparam int unsigned PH_W   = 4;
  localparam logic [PH_W-1:0] PH_ACC0 = PH_W'(2);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(NUM_TAPS + 2);
  localparam logic [PH_W-1:0] PH_END  = PH_W'(NUM_TAPS + 3);

  logic [STATE_W-1:0]         state;
  logic [STATE_W-1:0]         state_nxt;
  logic                       enter_rec_c;
  logic                       enter_play_c;
  logic                       start_mix_c;
  logic                       mix_out_c;
  logic                       mix_end_c;
  logic                       last_c;
  logic [LEN_W-1:0]           playhead;
  logic [PH_W-1:0]            phase;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    tap_ext_c;
  logic signed [ACC_W-1:0]    tap_val_c;
  logic signed [ACC_W-1:0]    sum_c;
  logic signed [SAMPLE_W-1:0] sat_c;
  tap_idx_t                   acc_tap_c;
  logic                       tap_ok_c;
  logic                       acc_en_c;
  logic [ADDR_W-1:0]          rd_addr_c;
  logic [ADDR_W-1:0]          wr_addr_q;
  logic signed [SAMPLE_W-1:0] wr_data_q;
  logic signed [SAMPLE_W-1:0] rd_data;
  logic                       wr_en_q;

  sample_ram #(
    .WIDTH(SAMPLE_W),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk_in (clk_in),
    .wr_en  (wr_en_q),
    .wr_addr(wr_addr_q),
    .wr_data(wr_data_q),
    .rd_addr(rd_addr_c),
    .rd_data(rd_data)
  );

  assign last_c = (playhead == recording_length - LEN_W'(1));

  // Read k is issued in mix phase k; tap k's data lands two phases later.
  always_comb begin
    rd_addr_c = ADDR_W'(32'(playhead) - 32'(phase) * TAP_STEP);
    acc_tap_c = TAP_W'(phase - PH_ACC0);
    acc_en_c  = (state == ST_MIX) && (phase >= PH_ACC0) && (phase <= PH_LAST);
    tap_ok_c  = 32'(playhead) >= 32'(acc_tap_c) * TAP_STEP;
    tap_ext_c = ACC_W'(rd_data);
    tap_val_c = '0;
    if (tap_ok_c) tap_val_c = tap_ext_c >>> acc_tap_c;
    sum_c = tap_val_c;
    if (phase != PH_ACC0) sum_c = acc + tap_val_c;
    sat_c = SAMPLE_W'(sat_to_sample(SAT_IN_W'(sum_c), SAMPLE_W));
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Record always wins; a mix in flight finishes unless record aborts it.
  always_comb begin
    state_nxt    = state;
    enter_rec_c  = 1'b0;
    enter_play_c = 1'b0;
    start_mix_c  = 1'b0;
    mix_out_c    = 1'b0;
    mix_end_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (record_in) begin
          state_nxt   = ST_RECORD;
          enter_rec_c = 1'b1;
        end else if (play_in && (recording_length != '0)) begin
          state_nxt    = ST_PLAY;
          enter_play_c = 1'b1;
        end
      end
      ST_RECORD: begin
        if (!record_in) state_nxt = ST_IDLE;
      end
      ST_PLAY: begin
        if (record_in) begin
          state_nxt   = ST_RECORD;
          enter_rec_c = 1'b1;
        end else if (!play_in) begin
          state_nxt = ST_IDLE;
        end else if (audio_valid_in) begin
          state_nxt   = ST_MIX;
          start_mix_c = 1'b1;
        end
      end
      ST_MIX: begin
        if (record_in) begin
          state_nxt   = ST_RECORD;
          enter_rec_c = 1'b1;
        end else begin
          mix_out_c = (phase == PH_LAST);
          if (phase == PH_END) begin
            mix_end_c = 1'b1;
            if (!play_in) state_nxt = ST_IDLE;
`ifdef ECHO_LOOP_PLAYBACK_EN
            else          state_nxt = ST_PLAY;
`else
            else if (last_c) state_nxt = ST_DONE;
            else             state_nxt = ST_PLAY;
`endif
          end
        end
      end
      ST_DONE: begin
        if (record_in) begin
          state_nxt   = ST_RECORD;
          enter_rec_c = 1'b1;
        end else if (!play_in) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      recording_length <= '0;
      full_out         <= 1'b0;
      sample_out       <= '0;
      sample_valid_out <= 1'b0;
      finish_out       <= 1'b0;
      overrun_out      <= 1'b0;
      playhead         <= '0;
      phase            <= '0;
      acc              <= '0;
      wr_en_q          <= 1'b0;
      wr_addr_q        <= '0;
      wr_data_q        <= '0;
    end else begin
      sample_valid_out <= 1'b0;
      finish_out       <= 1'b0;
      overrun_out      <= 1'b0;
      wr_en_q          <= 1'b0;
      // Capture: the RAM write lands one cycle after the strobe.
      if (enter_rec_c) begin
        recording_length <= '0;
        full_out         <= 1'b0;
      end else if ((state == ST_RECORD) && record_in && audio_valid_in && !full_out) begin
        wr_en_q          <= 1'b1;
        wr_addr_q        <= ADDR_W'(recording_length);
        wr_data_q        <= audio_in;
        recording_length <= recording_length + LEN_W'(1);
        full_out         <= (recording_length + LEN_W'(1)) == LEN_W'(DEPTH);
      end
      if (start_mix_c)            phase <= '0;
      else if (state == ST_MIX)   phase <= phase + PH_W'(1);
      if (acc_en_c)               acc   <= sum_c;
      if (mix_out_c) begin
        sample_out       <= sat_c;
        sample_valid_out <= 1'b1;
        finish_out       <= last_c;
      end
      if (enter_play_c)   playhead <= '0;
      else if (mix_end_c) playhead <= last_c ? '0 : playhead + LEN_W'(1);
      if ((state == ST_MIX) && audio_valid_in && !record_in) overrun_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_echo_recorder.sv
// Directed bench for echo_recorder with a take/mix model and a per-cycle output checker.
module tb_echo_recorder;

  localparam int SW      = 8;
  localparam int DEPTH   = 16;
  localparam int NT      = 2;
  localparam int STEP    = 4;
  localparam int SPACING = 10;
  localparam int LEN_W   = $clog2(DEPTH + 1);

  logic                    clk_in = 1'b0;
  logic                    rst_n_in;
  logic                    record_in;
  logic                    play_in;
  logic signed [SW-1:0]    audio_in;
  logic                    audio_valid_in;
  logic signed [SW-1:0]    sample_out;
  logic                    sample_valid_out;
  logic [LEN_W-1:0]        recording_length;
  logic                    full_out;
  logic                    finish_out;
  logic                    overrun_out;

  always #5 clk_in = ~clk_in;

  echo_recorder #(
    .SAMPLE_W(SW),
    .DEPTH   (DEPTH),
    .NUM_TAPS(NT),
    .TAP_STEP(STEP)
  ) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .record_in       (record_in),
    .play_in         (play_in),
    .audio_in        (audio_in),
    .audio_valid_in  (audio_valid_in),
    .sample_out      (sample_out),
    .sample_valid_out(sample_valid_out),
    .recording_length(recording_length),
    .full_out        (full_out),
    .finish_out      (finish_out),
    .overrun_out     (overrun_out)
  );

  typedef struct {
    int due;
    int val;
    bit fin;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   ovr_due = -1;
  int   take [DEPTH];
  int   m_len = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // Dry sample plus each in-range tap k, shifted right by k, then clamped.
  function automatic int model_mix(input int p);
    int s = 0;
    for (int k = 0; k <= NT; k++)
      if (p >= k * STEP) s += take[p - k * STEP] >>> k;
    if (s > (1 << (SW - 1)) - 1) s = (1 << (SW - 1)) - 1;
    if (s < -(1 << (SW - 1)))    s = -(1 << (SW - 1));
    return s;
  endfunction

  always @(negedge clk_in) begin
    bit   ev;
    exp_t e;
    if (cyc > 0) begin
      ev = 1'b0;
      if (expq.size() > 0 && expq[0].due == cyc) begin
        ev = 1'b1;
        e  = expq.pop_front();
      end
      chk("sample_valid_out", int'(sample_valid_out), int'(ev));
      if (ev) begin
        chk("sample_out", int'(sample_out), e.val);
        chk("finish_out", int'(finish_out), int'(e.fin));
      end else begin
        chk("finish_out_quiet", int'(finish_out), 0);
      end
      chk("overrun_out", int'(overrun_out), int'(cyc == ovr_due));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic strobe(input int v);
    audio_in       = SW'(v);
    audio_valid_in = 1'b1;
    tick(1);
    audio_valid_in = 1'b0;
  endtask

  task automatic record_take(input int n, input int base, input int inc);
    int v;
    record_in = 1'b1;
    tick(2);
    m_len = 0;
    for (int i = 0; i < n; i++) begin
      v = base + i * inc;
      strobe(v);
      if (m_len < DEPTH) begin
        take[m_len] = v;
        m_len++;
      end
      tick(SPACING - 1);
      chk("recording_length", int'(recording_length), m_len);
      chk("full_out", int'(full_out), int'(m_len == DEPTH));
    end
    record_in = 1'b0;
    tick(2);
  endtask

  task automatic play_take(input int n);
    int ph   = 0;
    bit done = 1'b0;
    play_in = 1'b1;
    tick(2);
    for (int i = 0; i < n; i++) begin
      if (!done) begin
        expq.push_back('{cyc + NT + 4, model_mix(ph), ph == m_len - 1});
        if (ph == m_len - 1) begin
`ifdef ECHO_LOOP_PLAYBACK_EN
          ph = 0;
`else
          done = 1'b1;
`endif
        end else begin
          ph++;
        end
      end
      strobe(0);
      tick(SPACING - 1);
    end
    play_in = 1'b0;
    tick(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n_in       = 1'b0;
    record_in      = 1'b0;
    play_in        = 1'b0;
    audio_in       = '0;
    audio_valid_in = 1'b0;
    tick(3);
    chk("reset_sample_out", int'(sample_out), 0);
    chk("reset_length", int'(recording_length), 0);
    chk("reset_full", int'(full_out), 0);
    rst_n_in = 1'b1;
    tick(2);

    // Constant take: dry-only until the first tap comes into range.
    record_take(8, 40, 0);
    chk("len_after_8", int'(recording_length), 8);
    chk("model_p0", model_mix(0), 40);
    chk("model_p4", model_mix(4), 60);
    play_take(8);
    chk("last_out_40_take", int'(sample_out), 60);

    // Overflowing take: writes beyond DEPTH are dropped.
    record_take(20, 1, 1);
    chk("len_full", int'(recording_length), 16);
    chk("full_set", int'(full_out), 1);
    chk("model_p8_ramp", model_mix(8), 11);
    play_take(16);

    // Overrun: a strobe 3 cycles into a mix is dropped; 7-cycle spacing is accepted.
    play_in = 1'b1;
    tick(2);
    expq.push_back('{cyc + NT + 4, model_mix(0), 1'b0});
    strobe(0);
    tick(2);
    ovr_due = cyc + 1;
    strobe(0);
    tick(3);
    expq.push_back('{cyc + NT + 4, model_mix(1), 1'b0});
    strobe(0);
    tick(SPACING);
    chk("after_overrun_out", int'(sample_out), 2);
    play_in = 1'b0;
    tick(3);

    // Saturation in both directions.
    record_take(12, 127, 0);
    chk("model_pos_sat", model_mix(8), 127);
    play_take(12);
    chk("pos_sat_out", int'(sample_out), 127);
    record_take(12, -128, 0);
    chk("model_neg_sat", model_mix(5), -128);
    play_take(12);
    chk("neg_sat_out", int'(sample_out), -128);

    // Short take played past its end: loops or holds depending on build.
    record_take(4, 10, 10);
    play_take(8);
    chk("short_take_hold", int'(sample_out), 40);

    // Reset three cycles into a mix: outputs clear immediately and nothing follows.
    play_in = 1'b1;
    tick(2);
    strobe(0);
    tick(2);
    rst_n_in = 1'b0;
    #1;
    chk("rst_mid_sample_out", int'(sample_out), 0);
    chk("rst_mid_valid", int'(sample_valid_out), 0);
    chk("rst_mid_length", int'(recording_length), 0);
    chk("rst_mid_full", int'(full_out), 0);
    chk("rst_mid_overrun", int'(overrun_out), 0);
    tick(2);
    rst_n_in = 1'b1;
    tick(4);
    strobe(0);
    tick(SPACING);
    chk("post_rst_length", int'(recording_length), 0);
    chk("post_rst_sample_out", int'(sample_out), 0);
    play_in = 1'b0;
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
